// File: rtl/dp_bram_pipe.sv
// rtl/dp_bram_pipe.sv - simple-dual-port BRAM with byte-lane writes, 1/2-cycle read pipeline, collision policy
// Optional macro DP_BRAM_INIT_CLEAR_EN: zero the array after reset while init_busy is high.
module dp_bram_pipe #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int READ_LAT    = 1,
    parameter int WRITE_FIRST = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                collision,
    output logic                init_busy
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] ram [DEPTH];

    logic              user_ok;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              rd_acc;
    logic              coll_hit;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [NB-1:0]     ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] rd_word;

    logic              s1_valid;
    logic              s1_coll;
    logic [DATA_W-1:0] s1_data;

`ifdef DP_BRAM_INIT_CLEAR_EN
    typedef enum logic {CLEAR, RUN} state_t;
    state_t           state;
    logic [IDX_W-1:0] clr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            init_busy <= 1'b1;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                state     <= RUN;
                init_busy <= 1'b0;
            end
        end
    end

    assign user_ok = (state == RUN);
`else
    assign user_ok   = 1'b1;
    assign init_busy = 1'b0;
`endif

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
    assign rd_acc      = rd_en & user_ok;
    assign coll_hit    = wr_en & rd_en & (wr_addr == rd_addr) & (|wr_be);

    always_comb begin
        ram_we    = wr_en & wr_in_range & user_ok;
        ram_waddr = wr_addr[IDX_W-1:0];
        ram_be    = wr_be;
        ram_wdata = wr_data;
`ifdef DP_BRAM_INIT_CLEAR_EN
        // The clear sweep owns the write port until the FSM reaches RUN.
        if (!user_ok) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_be    = '1;
            ram_wdata = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < NB; i++) begin
                if (ram_be[i]) ram[ram_waddr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
    end

    // Write-first substitutes the incoming bytes; untouched lanes keep the stored value.
    always_comb begin
        old_word = rd_in_range ? ram[rd_addr[IDX_W-1:0]] : '0;
        rd_word  = old_word;
        if ((WRITE_FIRST != 0) && coll_hit && rd_in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_coll  <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_acc;
            s1_coll  <= rd_acc & coll_hit;
            if (rd_acc) s1_data <= rd_word;
        end
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            assign rd_data   = s1_data;
            assign rd_valid  = s1_valid;
            assign collision = s1_coll;
        end else begin : g_lat2
            logic [DATA_W-1:0] s2_data;
            logic              s2_valid;
            logic              s2_coll;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_data  <= '0;
                    s2_valid <= 1'b0;
                    s2_coll  <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_coll  <= s1_coll;
                    if (s1_valid) s2_data <= s1_data;
                end
            end

            assign rd_data   = s2_data;
            assign rd_valid  = s2_valid;
            assign collision = s2_coll;
        end
    endgenerate
endmodule

// File: tb/tb_dp_bram_pipe.sv
// tb/tb_dp_bram_pipe.sv - scoreboard bench for dp_bram_pipe (read-first/lat1 and write-first/lat2 instances)
`timescale 1ns/1ps
module tb_dp_bram_pipe;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 5;

    typedef struct {
        logic [DW-1:0] data;
        logic          coll;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_be;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b, coll_a, coll_b, busy_a, busy_b;

    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] mem [DEPTH];
    int            checks;
    int            failures;
    int            cyc = 0;

    dp_bram_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(1), .WRITE_FIRST(0)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .collision(coll_a), .init_busy(busy_a));

    dp_bram_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(2), .WRITE_FIRST(1)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .collision(coll_b), .init_busy(busy_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_cycle(input logic we, input logic [AW-1:0] wa, input logic [3:0] be,
                            input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        exp_t          ea, eb;
        logic [DW-1:0] old, mrg;
        logic          hit;
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
        old = (int'(ra) < DEPTH) ? mem[ra[3:0]] : '0;
        hit = we && re && (wa == ra) && (be != 4'h0);
        mrg = old;
        if (int'(ra) < DEPTH)
            for (int i = 0; i < 4; i++) if (hit && be[i]) mrg[8*i +: 8] = wd[8*i +: 8];
        if (re) begin
            ea.data = old; ea.coll = hit; ea.due = cyc + 1; qa.push_back(ea);
            eb.data = mrg; eb.coll = hit; eb.due = cyc + 2; qb.push_back(eb);
        end
        if (we && int'(wa) < DEPTH)
            for (int i = 0; i < 4; i++) if (be[i]) mem[wa[3:0]][8*i +: 8] = wd[8*i +: 8];
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        wr_en = 1'b0; wr_be = 4'h0; rd_en = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            checks++;
            if (rd_valid_a === 1'b1) begin
                if (qa.size() == 0) begin
                    failures++; $display("FAIL a_unexpected_valid got rd_valid=1 want 0 cycle=%0d", cyc);
                end else begin
                    e = qa.pop_front();
                    if (rd_data_a !== e.data || coll_a !== e.coll || cyc != e.due) begin
                        failures++;
                        $display("FAIL a_read got data=%h coll=%b cycle=%0d want data=%h coll=%b cycle=%0d",
                                 rd_data_a, coll_a, cyc, e.data, e.coll, e.due);
                    end
                end
            end else if (rd_valid_a !== 1'b0 || coll_a !== 1'b0) begin
                failures++; $display("FAIL a_idle got rd_valid=%b coll=%b want 0 0", rd_valid_a, coll_a);
            end else if (qa.size() > 0 && qa[0].due <= cyc) begin
                failures++; $display("FAIL a_missing_valid got rd_valid=0 want 1 cycle=%0d", cyc);
                void'(qa.pop_front());
            end
            checks++;
            if (rd_valid_b === 1'b1) begin
                if (qb.size() == 0) begin
                    failures++; $display("FAIL b_unexpected_valid got rd_valid=1 want 0 cycle=%0d", cyc);
                end else begin
                    e = qb.pop_front();
                    if (rd_data_b !== e.data || coll_b !== e.coll || cyc != e.due) begin
                        failures++;
                        $display("FAIL b_read got data=%h coll=%b cycle=%0d want data=%h coll=%b cycle=%0d",
                                 rd_data_b, coll_b, cyc, e.data, e.coll, e.due);
                    end
                end
            end else if (rd_valid_b !== 1'b0 || coll_b !== 1'b0) begin
                failures++; $display("FAIL b_idle got rd_valid=%b coll=%b want 0 0", rd_valid_b, coll_b);
            end else if (qb.size() > 0 && qb[0].due <= cyc) begin
                failures++; $display("FAIL b_missing_valid got rd_valid=0 want 1 cycle=%0d", cyc);
                void'(qb.pop_front());
            end
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40 && busy_a !== 1'b0; i++) begin @(posedge clk); #1; end
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            failures++; $display("FAIL init_done got busy=%b/%b want 0/0", busy_a, busy_b);
        end
    endtask

    task automatic test_reset();
        logic exp_busy;
`ifdef DP_BRAM_INIT_CLEAR_EN
        exp_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
`else
        exp_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hBAD0_0000;
`endif
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = 4'h0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
        qa.delete(); qb.delete();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd_data_a !== '0 || rd_data_b !== '0 || rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 ||
            coll_a !== 1'b0 || coll_b !== 1'b0 || busy_a !== exp_busy || busy_b !== exp_busy) begin
            failures++;
            $display("FAIL reset_state got data=%h/%h valid=%b/%b coll=%b/%b busy=%b/%b want zeros busy=%b",
                     rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, coll_a, coll_b, busy_a, busy_b, exp_busy);
        end
        rst_n = 1'b1;
        wait_ready();
    endtask

    task automatic test_basic();
        do_cycle(1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 1'b0, 5'd0);
        do_cycle(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd5);
        idle(4);
        checks++;
        if (rd_data_a !== 32'hDEADBEEF || rd_data_b !== 32'hDEADBEEF || rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold got %h/%h valid=%b/%b want deadbeef valid=0", rd_data_a, rd_data_b, rd_valid_a, rd_valid_b);
        end
    endtask

    task automatic test_byte_enable();
        do_cycle(1'b1, 5'd7, 4'hF, 32'h11223344, 1'b0, 5'd0);
        do_cycle(1'b1, 5'd7, 4'b0101, 32'hAABBCCDD, 1'b0, 5'd0);
        do_cycle(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd7);
        do_cycle(1'b1, 5'd7, 4'h0, 32'hFFFFFFFF, 1'b0, 5'd0);
        do_cycle(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd7);
        idle(4);
        checks++;
        if (rd_data_a !== 32'h11BB33DD || rd_data_b !== 32'h11BB33DD) begin
            failures++; $display("FAIL byte_enable got %h/%h want 11bb33dd", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_collision();
        do_cycle(1'b1, 5'd9, 4'hF, 32'h1, 1'b0, 5'd0);
        do_cycle(1'b1, 5'd9, 4'hF, 32'h2, 1'b1, 5'd9);
        do_cycle(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd9);
        do_cycle(1'b1, 5'd9, 4'b0011, 32'hAAAA5555, 1'b1, 5'd9);
        do_cycle(1'b1, 5'd9, 4'h0, 32'h77777777, 1'b1, 5'd9);
        do_cycle(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd9);
        idle(4);
        checks++;
        if (rd_data_a !== 32'h00005555 || rd_data_b !== 32'h00005555) begin
            failures++; $display("FAIL collision_final got %h/%h want 00005555", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_out_of_range();
        do_cycle(1'b1, 5'd0, 4'hF, 32'h12345678, 1'b0, 5'd0);
        do_cycle(1'b1, 5'd16, 4'hF, 32'hCAFEF00D, 1'b0, 5'd0);
        do_cycle(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd0);
        do_cycle(1'b1, 5'd31, 4'hF, 32'hCAFEF00D, 1'b1, 5'd31);
        do_cycle(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd16);
        idle(4);
        checks++;
        if (rd_data_a !== '0 || rd_data_b !== '0) begin
            failures++; $display("FAIL out_of_range got %h/%h want 0", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++)
            do_cycle(1'b1, AW'(i), 4'hF, $urandom, (i > 0), AW'(i > 0 ? i - 1 : 0));
        for (int i = 0; i < DEPTH; i++)
            do_cycle(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, AW'(i));
        idle(4);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++; $display("FAIL stream_drain got pending=%0d/%0d want 0/0", qa.size(), qb.size());
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 8; i++)
            do_cycle(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, AW'(i));
        #2;
        checks++;
        if (rd_valid_a !== 1'b1 || rd_valid_b !== 1'b1) begin
            failures++; $display("FAIL midstream_active got valid=%b/%b want 1/1", rd_valid_a, rd_valid_b);
        end
        rst_n = 1'b0; rd_en = 1'b0;
        qa.delete(); qb.delete();
        #1;
        checks++;
        if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0 || rd_data_a !== '0 || rd_data_b !== '0) begin
            failures++;
            $display("FAIL midstream_reset got valid=%b/%b data=%h/%h want 0", rd_valid_a, rd_valid_b, rd_data_a, rd_data_b);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
`ifdef DP_BRAM_INIT_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
`endif
        wait_ready();
        idle(4);
    endtask

`ifdef DP_BRAM_INIT_CLEAR_EN
    task automatic test_init_clear();
        int n;
        rst_n = 1'b0; qa.delete(); qb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd3; wr_be = 4'hF; wr_data = 32'hFFFFFFFF; rd_en = 1'b1; rd_addr = 5'd3;
        n = 0;
        @(negedge clk);
        while (busy_a === 1'b1 && n < 40) begin
            n++;
            if (n == 10) begin wr_en = 1'b0; rd_en = 1'b0; end
            @(negedge clk);
        end
        checks++;
        if (n != DEPTH || busy_b !== 1'b0) begin
            failures++; $display("FAIL init_busy_cycles got %0d busy_b=%b want %0d busy_b=0", n, busy_b, DEPTH);
        end
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        for (int i = 0; i < DEPTH; i++)
            do_cycle(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, AW'(i));
        idle(4);
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_byte_enable();
        test_collision();
        test_out_of_range();
        test_back_to_back();
        test_reset_midstream();
`ifdef DP_BRAM_INIT_CLEAR_EN
        test_init_clear();
`endif
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
